dcache_miss_sequencer: RTL and testbench
========================================

Name: dcache_miss_sequencer

Overview:
- Sequences one data-cache set through a read or write miss:
  1. Probe the tag/flags and line at the miss index.
  2. Write back the victim line if it is valid and dirty.
  3. Fill the line requested-word-first from memory.
  4. Validate the new tag.
- Sits between the DCache hit/miss controller (miss requester) and the 128x64 set's fill, writeback and validate command ports.
- Owns the set's Index/Tag/Line* inputs only while busy; the hit controller muxes on Ready.

Parameters:
- PABITS, 36, physical address width. Tag width is PABITS-10, line address width is PABITS-4, word address width is PABITS-2.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- MissReq  in  1  miss request, sampled only when Ready=1.
- MissTag  in  PABITS-10  physical tag of the missing address.
- MissIndex  in  6  set index.
- MissOffset  in  2  word offset of the critical word.
- Ready  out  1  idle and able to accept MissReq.
- Done  out  1  one-cycle pulse when the line is valid.
- CritValid  out  1  one-cycle pulse when the critical word arrives (early restart).
- CritWord  out  32  critical word; valid only with CritValid.
- SetTag  out  PABITS-10  drives set Tag.
- SetIndex  out  6  drives set Index.
- SetLineIndex  out  6  drives set LineIndex.
- SetLineOffset  out  2  drives set LineOffset.
- SetLineIn  out  32  drives set LineIn.
- SetFillLine  out  1  drives set FillLine.
- SetValidateLine  out  1  drives set ValidateLine.
- SetValid  in  1  set Valid flag (one-cycle delayed).
- SetDirty  in  1  set Dirty flag (one-cycle delayed).
- SetIndexTag  in  PABITS-10  resident tag (one-cycle delayed).
- SetLineOut  in  128  resident line, word 0 in [31:0] (one-cycle delayed).
- MemWrReq  out  1  writeback request, level.
- MemWrAddr  out  PABITS-4  writeback line address.
- MemWrData  out  128  writeback line.
- MemWrAck  in  1  writeback accepted.
- MemRdReq  out  1  fill request, level.
- MemRdAddr  out  PABITS-2  critical word address.
- MemRdData  in  32  fill word.
- MemRdValid  in  1  fill word strobe.

Behaviour:
- Reset (async, reset=0):
  - State=IDLE.
  - Ready=1.
  - All strobes and requests (Done, CritValid, SetFillLine, SetValidateLine, MemWrReq, MemRdReq) = 0.
  - Address and data registers = 0.
- States: IDLE, PROBE, CHECK, WB, FILL, VALIDATE.
- IDLE:
  - Ready=1.
  - MissReq=1 latches {MissTag, MissIndex, MissOffset} → PROBE.
- PROBE:
  - SetIndex and SetLineIndex = latched index; set outputs are produced next cycle.
  - Unconditionally → CHECK.
- CHECK:
  - Sample SetValid, SetDirty, SetIndexTag and SetLineOut.
  - Capture SetLineOut into a writeback register.
  - If Valid&Dirty → WB; otherwise → FILL.
- WB:
  - MemWrReq=1, MemWrAddr={captured IndexTag, index}, MemWrData=captured line.
  - All three are held stable until MemWrAck=1 is sampled; then → FILL.
  - Ack is ignored in every other state.
- FILL:
  - MemRdReq=1, MemRdAddr={tag, index, offset}.
  - A 2-bit word counter cnt is cleared on entry.
  - Each MemRdValid, in the same cycle and combinationally:
    - SetFillLine=1, SetLineIn=MemRdData, SetLineIndex=index.
    - SetLineOffset=offset+cnt (mod 4: wraps 3→0).
  - cnt increments on each MemRdValid.
  - The first word also asserts CritValid=1 with CritWord=MemRdData.
  - MemRdReq drops in the cycle after the 4th word; on the 4th word → VALIDATE.
- VALIDATE:
  - SetValidateLine=1, SetTag=latched tag, SetIndex=latched index, Done=1 (same cycle).
  - → IDLE. Ready=1 next cycle; the new tag is visible to a probe issued then.
- Strobes outside their states:
  - MemRdValid outside FILL (or beyond the 4th word) is ignored; SetFillLine stays 0.
  - MissReq while Ready=0 is ignored; it is not queued.
- Reset mid-operation:
  - Immediate return to IDLE; requests deassert asynchronously.
  - A partial fill leaves the line invalid (no ValidateLine); an in-flight writeback is abandoned.
- Backpressure: MemWrAck and MemRdValid may stall indefinitely; the FSM waits with all outputs stable.

Test Plan:
- Clean miss: Valid=1, Dirty=0, MissOffset=2, memory returns 0xA,0xB,0xC,0xD → no MemWrReq; FillLine offsets 2,3,0,1; CritValid with CritWord=0xA; Done 1 cycle after the 4th word; Ready at MissReq+1 is 0.
- Dirty victim: Valid=1, Dirty=1, IndexTag=0x123, MissIndex=5 → MemWrAddr={0x123,5}, MemWrData equals the line captured in CHECK; MemWrReq held 7 cycles until MemWrAck; fill begins the cycle after the ack.
- Invalid but dirty flag (Valid=0, Dirty=1) → writeback skipped; straight to FILL.
- Stalled fill: 5 idle cycles between words 2 and 3 → MemRdReq stays high, FillLine only on strobes; extra MemRdValid after Done → no FillLine.
- reset=0 asserted mid-FILL after 2 words → Ready=1, MemRdReq=0 asynchronously; no ValidateLine; the next MissReq restarts at PROBE.
- MissReq pulsed while busy → ignored; exactly one Done per accepted request.

Source files
------------

// File: rtl/dcache_miss_sequencer.sv
// Walks one data-cache set through a miss: probe, optional dirty writeback,
// critical-word-first fill, then tag validation.
//
// Ports
//   clock, reset            rising-edge clock, async active-low reset
//   MissReq/Tag/Index/Off   miss request from the hit controller (taken when Ready)
//   Ready, Done             idle flag, one-cycle completion pulse
//   CritValid, CritWord     early-restart strobe and data for the critical word
//   Set*                    command/response bus of the 128x64 set
//   MemWr*                  line writeback channel (level request, ack)
//   MemRd*                  word fill channel (level request, data strobe)
module dcache_miss_sequencer #(
  parameter int PABITS = 36
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 MissReq,
  input  logic [PABITS-11:0]   MissTag,
  input  logic [5:0]           MissIndex,
  input  logic [1:0]           MissOffset,
  output logic                 Ready,
  output logic                 Done,
  output logic                 CritValid,
  output logic [31:0]          CritWord,
  output logic [PABITS-11:0]   SetTag,
  output logic [5:0]           SetIndex,
  output logic [5:0]           SetLineIndex,
  output logic [1:0]           SetLineOffset,
  output logic [31:0]          SetLineIn,
  output logic                 SetFillLine,
  output logic                 SetValidateLine,
  input  logic                 SetValid,
  input  logic                 SetDirty,
  input  logic [PABITS-11:0]   SetIndexTag,
  input  logic [127:0]         SetLineOut,
  output logic                 MemWrReq,
  output logic [PABITS-5:0]    MemWrAddr,
  output logic [127:0]         MemWrData,
  input  logic                 MemWrAck,
  output logic                 MemRdReq,
  output logic [PABITS-3:0]    MemRdAddr,
  input  logic [31:0]          MemRdData,
  input  logic                 MemRdValid
);

  typedef enum logic [2:0] {
    IDLE, PROBE, CHECK, WB, FILL, VALIDATE
  } state_t;

  state_t state, stateNext;

  logic [PABITS-11:0] tagQ;
  logic [PABITS-11:0] wbTagQ;
  logic [5:0]         indexQ;
  logic [1:0]         offsetQ;
  logic [1:0]         cnt;
  logic [127:0]       wbLineQ;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext       = state;
    Ready           = 1'b0;
    Done            = 1'b0;
    CritValid       = 1'b0;
    CritWord        = '0;
    SetLineIn       = '0;
    SetFillLine     = 1'b0;
    SetValidateLine = 1'b0;
    MemWrReq        = 1'b0;
    MemRdReq        = 1'b0;
    unique case (state)
      IDLE: begin
        Ready = 1'b1;
        if (MissReq) stateNext = PROBE;
      end
      PROBE: stateNext = CHECK;
      CHECK: stateNext = (SetValid && SetDirty) ? WB : FILL;
      WB: begin
        MemWrReq = 1'b1;
        if (MemWrAck) stateNext = FILL;
      end
      FILL: begin
        MemRdReq = 1'b1;
        if (MemRdValid) begin
          SetFillLine = 1'b1;
          SetLineIn   = MemRdData;
          if (cnt == 2'd0) begin
            CritValid = 1'b1;
            CritWord  = MemRdData;
          end
          if (cnt == 2'd3) stateNext = VALIDATE;
        end
      end
      VALIDATE: begin
        SetValidateLine = 1'b1;
        Done            = 1'b1;
        stateNext       = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tagQ    <= '0;
      indexQ  <= '0;
      offsetQ <= '0;
      wbTagQ  <= '0;
      wbLineQ <= '0;
      cnt     <= '0;
    end else begin
      if (state == IDLE && MissReq) begin
        tagQ    <= MissTag;
        indexQ  <= MissIndex;
        offsetQ <= MissOffset;
      end
      if (state == CHECK) begin
        wbTagQ  <= SetIndexTag;
        wbLineQ <= SetLineOut;
      end
      // Word counter only runs inside FILL; zero on every entry.
      if (state != FILL)  cnt <= '0;
      else if (MemRdValid) cnt <= cnt + 2'd1;
    end
  end

  // Wrapping offset gives requested-word-first order.
  assign SetLineOffset = offsetQ + cnt;
  assign SetTag        = tagQ;
  assign SetIndex      = indexQ;
  assign SetLineIndex  = indexQ;
  assign MemWrAddr     = {wbTagQ, indexQ};
  assign MemWrData     = wbLineQ;
  assign MemRdAddr     = {tagQ, indexQ, offsetQ};

endmodule

// File: tb/tb_dcache_miss_sequencer.sv
// Randomised bench for dcache_miss_sequencer with a set model, a memory
// driver and a transaction-level reference checked on every cycle.
module tb_dcache_miss_sequencer;
  localparam int PABITS = 36;
  localparam int TW = PABITS - 10;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic MissReq = 1'b0;
  logic [TW-1:0] MissTag = '0;
  logic [5:0] MissIndex = '0;
  logic [1:0] MissOffset = '0;
  logic Ready, Done, CritValid;
  logic [31:0] CritWord;
  logic [TW-1:0] SetTag;
  logic [5:0] SetIndex, SetLineIndex;
  logic [1:0] SetLineOffset;
  logic [31:0] SetLineIn;
  logic SetFillLine, SetValidateLine;
  logic SetValid = 1'b0, SetDirty = 1'b0;
  logic [TW-1:0] SetIndexTag = '0;
  logic [127:0] SetLineOut = '0;
  logic MemWrReq;
  logic [PABITS-5:0] MemWrAddr;
  logic [127:0] MemWrData;
  logic MemWrAck = 1'b0;
  logic MemRdReq;
  logic [PABITS-3:0] MemRdAddr;
  logic [31:0] MemRdData = '0;
  logic MemRdValid = 1'b0;

  dcache_miss_sequencer #(.PABITS(PABITS)) dut (
    .clock(clock), .reset(reset),
    .MissReq(MissReq), .MissTag(MissTag),
    .MissIndex(MissIndex), .MissOffset(MissOffset),
    .Ready(Ready), .Done(Done),
    .CritValid(CritValid), .CritWord(CritWord),
    .SetTag(SetTag), .SetIndex(SetIndex),
    .SetLineIndex(SetLineIndex), .SetLineOffset(SetLineOffset),
    .SetLineIn(SetLineIn), .SetFillLine(SetFillLine),
    .SetValidateLine(SetValidateLine),
    .SetValid(SetValid), .SetDirty(SetDirty),
    .SetIndexTag(SetIndexTag), .SetLineOut(SetLineOut),
    .MemWrReq(MemWrReq), .MemWrAddr(MemWrAddr),
    .MemWrData(MemWrData), .MemWrAck(MemWrAck),
    .MemRdReq(MemRdReq), .MemRdAddr(MemRdAddr),
    .MemRdData(MemRdData), .MemRdValid(MemRdValid)
  );

  int checks = 0;
  int errors = 0;

  task automatic chkEq(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Set model: flag/tag/line arrays, read with one cycle of latency.
  logic          vArr[64];
  logic          dArr[64];
  logic [TW-1:0] tArr[64];
  logic [127:0]  lArr[64];

  always @(posedge clock) begin
    SetValid    <= vArr[SetIndex];
    SetDirty    <= dArr[SetIndex];
    SetIndexTag <= tArr[SetIndex];
    SetLineOut  <= lArr[SetIndex];
    if (SetFillLine)
      lArr[SetLineIndex][SetLineOffset*32 +: 32] = SetLineIn;
    if (SetValidateLine) begin
      vArr[SetIndex] = 1'b1;
      dArr[SetIndex] = 1'b0;
      tArr[SetIndex] = SetTag;
    end
  end

  // Reference expectations for the miss in flight.
  bit            active = 0;
  bit            expWb;
  logic [TW-1:0] expTag;
  logic [5:0]    expIdx;
  logic [1:0]    expOff;
  logic [31:0]   expWrAddr;
  logic [127:0]  expWrData;
  logic [33:0]   expRdAddr;
  logic [31:0]   words[4];
  int            fillSeen = 0;
  int            doneSeen = 0;
  bit            prevFourth = 0;
  bit            prevAck = 0;
  bit            wbAcked = 0;
  logic [31:0]   firstWrAddr = '0;
  logic [31:0]   critData = '0;

  always @(negedge clock) begin
    if (reset) begin
      if (!active) begin
        chkEq("idleReady", Ready, 1);
        chkEq("idleRdReq", MemRdReq, 0);
        chkEq("idleWrReq", MemWrReq, 0);
        chkEq("idleFill", SetFillLine, 0);
        chkEq("idleDone", Done, 0);
      end else begin
        if (prevAck) chkEq("fillAfterAck", MemRdReq, 1);
        if (prevFourth) chkEq("doneAfter4th", Done, 1);
        prevFourth = 0;
        prevAck = MemWrReq && MemWrAck;
        if (prevAck) wbAcked = 1;
        if (MemWrReq) begin
          chkEq("wbWanted", {127'd0, expWb}, 1);
          chkEq("wrAddr", MemWrAddr, expWrAddr);
          chkEq("wrData", MemWrData, expWrData);
          chkEq("wrRdOverlap", MemRdReq, 0);
          firstWrAddr = MemWrAddr;
        end
        if (MemRdReq) begin
          chkEq("rdAddr", MemRdAddr, expRdAddr);
          if (expWb) chkEq("wbBeforeFill", {127'd0, wbAcked}, 1);
        end
        if (SetFillLine) begin
          chkEq("fillNeedsReq", MemRdReq, 1);
          chkEq("fillOffset", SetLineOffset, 2'(expOff + 2'(fillSeen)));
          chkEq("fillIndex", SetLineIndex, expIdx);
          chkEq("fillData", SetLineIn, words[fillSeen % 4]);
          chkEq("critValid", CritValid, (fillSeen == 0) ? 1 : 0);
          if (fillSeen == 0) begin
            chkEq("critWord", CritWord, words[0]);
            critData = CritWord;
          end
          fillSeen++;
          if (fillSeen == 4) prevFourth = 1;
        end else begin
          chkEq("critNoFill", CritValid, 0);
        end
        if (MemRdValid && !MemRdReq) chkEq("strayFill", SetFillLine, 0);
        if (Done) begin
          chkEq("doneWords", fillSeen, 4);
          chkEq("validate", SetValidateLine, 1);
          chkEq("valTag", SetTag, expTag);
          chkEq("valIndex", SetIndex, expIdx);
          doneSeen++;
        end else begin
          chkEq("noValidate", SetValidateLine, 0);
        end
      end
    end
  end

  task automatic doMiss(input logic [TW-1:0] tag, input logic [5:0] idx,
                        input logic [1:0] off, input bit v, input bit d,
                        input logic [TW-1:0] vtag, input logic [127:0] line,
                        input logic [127:0] wpack, input int hold,
                        input int gap23, input bit rndGaps,
                        input int abortAt);
    int sent, wr, gapLeft, cyc, doneBefore;
    bit aborted;
    logic [127:0] expLine;
    vArr[idx] = v;
    dArr[idx] = d;
    tArr[idx] = vtag;
    lArr[idx] = line;
    expTag = tag;
    expIdx = idx;
    expOff = off;
    expWb = v && d;
    expWrAddr = {vtag, idx};
    expWrData = line;
    expRdAddr = {tag, idx, off};
    for (int k = 0; k < 4; k++) words[k] = wpack[k*32 +: 32];
    fillSeen = 0;
    prevFourth = 0;
    prevAck = 0;
    wbAcked = 0;
    doneBefore = doneSeen;
    @(posedge clock); #1;
    MissReq = 1'b1;
    MissTag = tag;
    MissIndex = idx;
    MissOffset = off;
    @(posedge clock); #1;
    active = 1;
    MissReq = 1'b0;
    chkEq("busyAfterReq", Ready, 0);
    sent = 0;
    wr = 0;
    cyc = 0;
    aborted = 0;
    gapLeft = rndGaps ? int'($urandom_range(2)) : 0;
    while (doneSeen == doneBefore && cyc < 300) begin
      if (abortAt > 0 && sent == abortAt) begin
        aborted = 1;
        break;
      end
      MissReq = !Ready && ($urandom_range(3) == 0);
      MissTag = TW'($urandom);
      MissIndex = 6'($urandom);
      if (MemWrReq) begin
        wr++;
        MemWrAck = (wr == hold);
      end else begin
        MemWrAck = ($urandom_range(3) == 0);
      end
      if (MemRdReq && sent < 4) begin
        if (gapLeft > 0) begin
          gapLeft--;
          MemRdValid = 1'b0;
          MemRdData = $urandom;
        end else begin
          MemRdValid = 1'b1;
          MemRdData = words[sent];
          sent++;
          if (sent == 2) gapLeft = gap23;
          else gapLeft = rndGaps ? int'($urandom_range(2)) : 0;
        end
      end else begin
        MemRdValid = ($urandom_range(2) == 0);
        MemRdData = $urandom;
      end
      @(posedge clock); #1;
      cyc++;
    end
    MissReq = 1'b0;
    MemRdValid = 1'b0;
    MemWrAck = 1'b0;
    if (aborted) begin
      active = 0;
      #1 reset = 1'b0;
      #1;
      chkEq("rstReady", Ready, 1);
      chkEq("rstRdReq", MemRdReq, 0);
      chkEq("rstFill", SetFillLine, 0);
      chkEq("rstValidate", SetValidateLine, 0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      chkEq("abortStillInvalid", vArr[idx], v);
      chkEq("abortNoDone", doneSeen, doneBefore);
    end else begin
      chkEq("missTimeout", {127'd0, cyc < 300}, 1);
      chkEq("oneDone", doneSeen, doneBefore + 1);
      chkEq("wbCycles", wr, expWb ? hold : 0);
      expLine = '0;
      for (int k = 0; k < 4; k++)
        expLine[((off + k) % 4) * 32 +: 32] = words[k];
      chkEq("lineFilled", lArr[idx], expLine);
      chkEq("lineValid", vArr[idx], 1);
      chkEq("lineClean", dArr[idx], 0);
      chkEq("lineTag", tArr[idx], tag);
      active = 0;
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      vArr[i] = 1'b0;
      dArr[i] = 1'b0;
      tArr[i] = '0;
      lArr[i] = '0;
    end
    repeat (3) @(posedge clock);
    #1;
    chkEq("rstReady0", Ready, 1);
    chkEq("rstRdReq0", MemRdReq, 0);
    chkEq("rstWrReq0", MemWrReq, 0);
    chkEq("rstDone0", Done, 0);
    chkEq("rstWrAddr0", MemWrAddr, 0);
    chkEq("rstRdAddr0", MemRdAddr, 0);
    reset = 1'b1;
    repeat (2) @(posedge clock);

    // Clean victim, critical word at offset 2.
    doMiss(26'h00abcde, 6'd3, 2'd2, 1'b1, 1'b0, 26'h0000077,
           {4{32'h5555_5555}},
           {32'hD, 32'hC, 32'hB, 32'hA}, 0, 0, 1'b0, 0);
    chkEq("pinLine", lArr[3],
          128'h0000000B_0000000A_0000000D_0000000C);
    chkEq("pinCrit", critData, 32'hA);

    // Dirty victim, writeback held for seven cycles.
    doMiss(26'h0000456, 6'd5, 2'd1, 1'b1, 1'b1, 26'h0000123,
           128'h01234567_89abcdef_fedcba98_76543210,
           {32'h44, 32'h33, 32'h22, 32'h11}, 7, 0, 1'b0, 0);
    chkEq("pinWrAddr", firstWrAddr, 32'h000048C5);

    // Dirty flag on an invalid line must not write back.
    doMiss(26'h0000999, 6'd9, 2'd0, 1'b0, 1'b1, 26'h0000321,
           {4{32'hdead_beef}},
           {32'h4, 32'h3, 32'h2, 32'h1}, 3, 0, 1'b0, 0);

    // Five idle cycles between the second and third words.
    doMiss(26'h0000aaa, 6'd12, 2'd3, 1'b1, 1'b0, 26'h0000bbb,
           '0, {32'h40, 32'h30, 32'h20, 32'h10}, 0, 5, 1'b0, 0);

    // Reset after two fill words, then a clean restart on the same set.
    doMiss(26'h0000ccc, 6'd20, 2'd1, 1'b0, 1'b0, 26'h0000000,
           '0, {32'h4444, 32'h3333, 32'h2222, 32'h1111}, 0, 0, 1'b0, 2);
    doMiss(26'h0000ddd, 6'd20, 2'd3, 1'b0, 1'b0, 26'h0000000,
           '0, {32'h8888, 32'h7777, 32'h6666, 32'h5555}, 0, 0, 1'b1, 0);

    for (int n = 0; n < 20; n++) begin
      doMiss(TW'($urandom), 6'($urandom), 2'($urandom),
             1'($urandom), 1'($urandom), TW'($urandom),
             {$urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom},
             1 + int'($urandom_range(4)), int'($urandom_range(3)),
             1'b1, 0);
    end

    repeat (3) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
